dm_codec_pipeline: RTL and testbench

Parametrised delta-modulation pipeline with four stages: sample fetch from a synchronous-read sample memory, 1-bit delta encoder, mirrored decoder, and moving-average filter. It replaces the fixed 8-bit, fixed-step, free-running chain with a start/busy/done run controller and a bounded sample count. It also adds an optional adaptive step size and a configurable averaging window. It sits between the sample BRAM and the board outputs.

---
 rtl/dm_codec_pkg.sv | 34 +++
 rtl/dm_codec_pipeline_integrator.sv | 59 +++++
 rtl/dm_codec_pipeline.sv | 158 +++++++++++++++
 tb/tb_dm_codec_pipeline.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_codec_pkg.sv
// Shared types and helpers for the delta-modulation codec pipeline.
// Holds the run FSM states and the saturating integrator arithmetic.
package dm_codec_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    // Largest signed value representable in w bits
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest signed value representable in w bits
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // Averaging window length for a log2 window size
    function automatic int win(input int l2);
        return 1 << l2;
    endfunction

    // est +/- step, clamped to the signed w-bit range
    function automatic int sat_step(input int est, input int step,
                                    input logic up, input int w);
        int r;
        r = up ? est + step : est - step;
        if (r > sat_max(w))
            r = sat_max(w);
        else if (r < sat_min(w))
            r = sat_min(w);
        return r;
    endfunction

endpackage

// File: rtl/dm_codec_pipeline_integrator.sv
// Estimate/step integrator shared by encoder and decoder.
// Both sides run the same instance so their estimates track exactly.
module dm_integrator
    import dm_codec_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int STEP     = 1,
    parameter int STEP_MAX = 16,
    parameter int ADAPTIVE = 0
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     bit_in,
    output logic signed [DATA_W-1:0] est
);

    logic [31:0] step;
    logic [31:0] step_nxt;
    logic [1:0]  hist;
    logic [1:0]  hval;
    logic        same2;
    logic        flip;

    // Next step: grow on a run of three equal bits, shrink on a flip
    always_comb begin
        step_nxt = step;
        same2    = hval[1] && (bit_in == hist[0]) && (bit_in == hist[1]);
        flip     = hval[0] && (bit_in != hist[0]);
        if (ADAPTIVE != 0) begin
            if (same2)
                step_nxt = ((step << 1) > STEP_MAX) ? STEP_MAX : (step << 1);
            else if (flip)
                step_nxt = ((step >> 1) < STEP) ? STEP : (step >> 1);
        end
    end

    // Integrate with the current step, then adopt the updated step
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            est  <= '0;
            step <= STEP;
            hist <= '0;
            hval <= '0;
        end else if (clear) begin
            est  <= '0;
            step <= STEP;
            hist <= '0;
            hval <= '0;
        end else if (en) begin
            est  <= DATA_W'(sat_step(int'(est), int'(step), bit_in, DATA_W));
            step <= step_nxt;
            hist <= {hist[0], bit_in};
            hval <= {hval[0], 1'b1};
        end
    end

endmodule

// File: rtl/dm_codec_pipeline.sv
// Delta-modulation run pipeline: fetch, encode, decode, moving average.
// A start/busy/done controller reads N_SAMPLES words then drains.
module dm_codec_pipeline
    import dm_codec_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int N_SAMPLES = 256,
    parameter int STEP      = 1,
    parameter int STEP_MAX  = 16,
    parameter int ADAPTIVE  = 0,
    parameter int AVG_LOG2  = 2
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     start,
    output logic                     mem_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic signed [DATA_W-1:0] mem_data,
    output logic                     enc_bit,
    output logic                     enc_valid,
    output logic signed [DATA_W-1:0] filtered,
    output logic                     filt_valid,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SAMPLES - 1);
    localparam int WIN = win(AVG_LOG2);
    localparam int SW  = DATA_W + AVG_LOG2;

    state_t                  state;
    logic                    rd_v;
    logic                    dec_valid;
    logic                    clear;
    logic                    cmp;
    logic signed [DATA_W-1:0] enc_est;
    logic signed [DATA_W-1:0] dec_est;
    logic signed [DATA_W-1:0] hist [WIN];
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     sum_nxt;

    assign clear = (state == IDLE) && start;
    assign cmp   = mem_data > enc_est;

    // Run controller: issue N_SAMPLES reads, drain, pulse done
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        mem_en   <= 1'b1;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_addr == LAST) begin
                        mem_en <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (dec_valid && !enc_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mem_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid strobes follow each read through the four stages
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            rd_v       <= 1'b0;
            enc_valid  <= 1'b0;
            dec_valid  <= 1'b0;
            filt_valid <= 1'b0;
            enc_bit    <= 1'b0;
        end else begin
            rd_v       <= mem_en;
            enc_valid  <= rd_v;
            dec_valid  <= enc_valid;
            filt_valid <= dec_valid;
            if (rd_v)
                enc_bit <= cmp;
        end
    end

    dm_integrator #(
        .DATA_W  (DATA_W),
        .STEP    (STEP),
        .STEP_MAX(STEP_MAX),
        .ADAPTIVE(ADAPTIVE)
    ) u_enc (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .clear    (clear),
        .en       (rd_v),
        .bit_in   (cmp),
        .est      (enc_est)
    );

    dm_integrator #(
        .DATA_W  (DATA_W),
        .STEP    (STEP),
        .STEP_MAX(STEP_MAX),
        .ADAPTIVE(ADAPTIVE)
    ) u_dec (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .clear    (clear),
        .en       (enc_valid),
        .bit_in   (enc_bit),
        .est      (dec_est)
    );

    assign sum_nxt = sum + SW'(dec_est) - SW'(hist[WIN-1]);

    // Running-sum moving average over the last WIN decoded samples
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sum      <= '0;
            filtered <= '0;
            for (int i = 0; i < WIN; i++)
                hist[i] <= '0;
        end else if (clear) begin
            sum      <= '0;
            filtered <= '0;
            for (int i = 0; i < WIN; i++)
                hist[i] <= '0;
        end else if (dec_valid) begin
            hist[0] <= dec_est;
            for (int i = 1; i < WIN; i++)
                hist[i] <= hist[i-1];
            sum      <= sum_nxt;
            filtered <= DATA_W'(sum_nxt >>> AVG_LOG2);
        end
    end

endmodule

// File: tb/tb_dm_codec_pipeline.sv
// Directed bench for dm_codec_pipeline across four parameter sets.
// Fixed, adaptive, saturating and single-sample runs.
module tb_dm_codec_pipeline;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] start, mem_en, enc_bit, enc_valid, filt_valid, busy, done;
    logic [7:0] mem_addr [4];
    logic signed [7:0] mem_data [4];
    logic signed [7:0] filtered [4];
    logic signed [7:0] val [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int an[4], en[4], fn[4], dn[4];
    int last_en[4], done_cyc[4], f_first[4], f_last[4];
    int av[4][128];
    int ev[4][128];
    int fv[4][128];

    int exp_bits[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1};
    int exp_filt[14] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int exp_ad[16] = '{1, 2, 3, 5, 9, 17, 33, 49, 65, 81, 97, 113,
                       97, 105, 101, 99};

    always #5 clk = ~clk;

    dm_codec_pipeline #(.DATA_W(8), .ADDR_W(8), .N_SAMPLES(14), .STEP(1),
        .STEP_MAX(16), .ADAPTIVE(0), .AVG_LOG2(2)) u_a (
        .CLK100MHZ(clk), .reset(reset), .start(start[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
        .enc_bit(enc_bit[0]), .enc_valid(enc_valid[0]),
        .filtered(filtered[0]), .filt_valid(filt_valid[0]),
        .busy(busy[0]), .done(done[0]));

    dm_codec_pipeline #(.DATA_W(8), .ADDR_W(8), .N_SAMPLES(16), .STEP(1),
        .STEP_MAX(16), .ADAPTIVE(1), .AVG_LOG2(0)) u_b (
        .CLK100MHZ(clk), .reset(reset), .start(start[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
        .enc_bit(enc_bit[1]), .enc_valid(enc_valid[1]),
        .filtered(filtered[1]), .filt_valid(filt_valid[1]),
        .busy(busy[1]), .done(done[1]));

    dm_codec_pipeline #(.DATA_W(8), .ADDR_W(8), .N_SAMPLES(40), .STEP(4),
        .STEP_MAX(16), .ADAPTIVE(0), .AVG_LOG2(0)) u_c (
        .CLK100MHZ(clk), .reset(reset), .start(start[2]),
        .mem_en(mem_en[2]), .mem_addr(mem_addr[2]), .mem_data(mem_data[2]),
        .enc_bit(enc_bit[2]), .enc_valid(enc_valid[2]),
        .filtered(filtered[2]), .filt_valid(filt_valid[2]),
        .busy(busy[2]), .done(done[2]));

    dm_codec_pipeline #(.DATA_W(8), .ADDR_W(8), .N_SAMPLES(1), .STEP(1),
        .STEP_MAX(16), .ADAPTIVE(0), .AVG_LOG2(2)) u_d (
        .CLK100MHZ(clk), .reset(reset), .start(start[3]),
        .mem_en(mem_en[3]), .mem_addr(mem_addr[3]), .mem_data(mem_data[3]),
        .enc_bit(enc_bit[3]), .enc_valid(enc_valid[3]),
        .filtered(filtered[3]), .filt_valid(filt_valid[3]),
        .busy(busy[3]), .done(done[3]));

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read sample memory returning a constant per instance
    always @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (mem_en[k]) mem_data[k] <= val[k];

    // Record strobed outputs away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_en[k]) begin
                if (an[k] < 128) av[k][an[k]] = int'(mem_addr[k]);
                an[k]++;
                last_en[k] = cyc;
            end
            if (enc_valid[k]) begin
                if (en[k] < 128) ev[k][en[k]] = int'(enc_bit[k]);
                en[k]++;
            end
            if (filt_valid[k]) begin
                if (fn[k] == 0) f_first[k] = cyc;
                f_last[k] = cyc;
                if (fn[k] < 128) fv[k][fn[k]] = int'(filtered[k]);
                fn[k]++;
            end
            if (done[k]) begin
                dn[k]++;
                done_cyc[k] = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr(input int k);
        an[k] = 0; en[k] = 0; fn[k] = 0; dn[k] = 0;
        last_en[k] = 0; done_cyc[k] = 0; f_first[k] = 0; f_last[k] = 0;
    endtask

    task automatic pulse(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int n, input int budget);
        int t;
        t = 0;
        while (dn[k] < n && t < budget) begin
            tick();
            t++;
        end
        chk($sformatf("done_count%0d", k), dn[k], n);
    endtask

    task automatic check_a_run(input string tag);
        chk({tag, "_reads"}, an[0], 14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("%s_addr[%0d]", tag, i), av[0][i], i);
        chk({tag, "_encn"}, en[0], 14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("%s_bit[%0d]", tag, i), ev[0][i], exp_bits[i]);
        chk({tag, "_filtn"}, fn[0], 14);
        for (int i = 0; i < 14; i++)
            chk($sformatf("%s_filt[%0d]", tag, i), fv[0][i], exp_filt[i]);
        chk({tag, "_done_lat"}, done_cyc[0] - last_en[0], 4);
        chk({tag, "_filt_span"}, f_last[0] - f_first[0], 13);
    endtask

    initial begin
        int neg;
        reset = 1'b1;
        start = '0;
        for (int k = 0; k < 4; k++) begin
            val[k] = '0;
            clr(k);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_mem_en", int'(mem_en[0]), 0);
        chk("rst_mem_addr", int'(mem_addr[0]), 0);
        chk("rst_enc_bit", int'(enc_bit[0]), 0);
        chk("rst_enc_valid", int'(enc_valid[0]), 0);
        chk("rst_filtered", int'(filtered[0]), 0);
        chk("rst_filt_valid", int'(filt_valid[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);

        // Fixed step, constant 10
        val[0] = 8'sd10;
        clr(0);
        pulse(0);
        chk("a_busy", int'(busy[0]), 1);
        wait_done(0, 1, 100);
        check_a_run("a1");
        chk("a_busy_after", int'(busy[0]), 0);

        // Back-to-back runs with start held high
        repeat (3) tick();
        clr(0);
        start[0] = 1'b1;
        wait_done(0, 2, 200);
        start[0] = 1'b0;
        repeat (10) tick();
        chk("b2b_reads", an[0], 28);
        chk("b2b_filtn", fn[0], 28);
        chk("b2b_dones", dn[0], 2);
        for (int i = 0; i < 28; i++) begin
            chk($sformatf("b2b_addr[%0d]", i), av[0][i], i % 14);
            chk($sformatf("b2b_filt[%0d]", i), fv[0][i], exp_filt[i % 14]);
        end

        // Reset in the middle of READ
        clr(0);
        pulse(0);
        repeat (4) tick();
        chk("mid_mem_en", int'(mem_en[0]), 1);
        chk("mid_enc_valid", int'(enc_valid[0]), 1);
        reset = 1'b1;
        #1;
        chk("abort_mem_en", int'(mem_en[0]), 0);
        chk("abort_mem_addr", int'(mem_addr[0]), 0);
        chk("abort_enc_bit", int'(enc_bit[0]), 0);
        chk("abort_enc_valid", int'(enc_valid[0]), 0);
        chk("abort_filtered", int'(filtered[0]), 0);
        chk("abort_filt_valid", int'(filt_valid[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        tick();
        reset = 1'b0;
        clr(0);
        repeat (30) tick();
        chk("abort_no_done", dn[0], 0);
        chk("abort_no_reads", an[0], 0);
        pulse(0);
        wait_done(0, 1, 100);
        check_a_run("a2");

        // Adaptive step, constant 100
        val[1] = 8'sd100;
        clr(1);
        pulse(1);
        wait_done(1, 1, 100);
        chk("ad_filtn", fn[1], 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ad_dec[%0d]", i), fv[1][i], exp_ad[i]);

        // Saturation high
        val[2] = 8'sd127;
        clr(2);
        pulse(2);
        wait_done(2, 1, 200);
        chk("sat_hi_n", fn[2], 40);
        chk("sat_hi_0", fv[2][0], 4);
        chk("sat_hi_30", fv[2][30], 124);
        chk("sat_hi_31", fv[2][31], 127);
        chk("sat_hi_32", fv[2][32], 123);
        chk("sat_hi_39", fv[2][39], 127);
        neg = 0;
        for (int i = 0; i < 40; i++)
            if (fv[2][i] < 0) neg++;
        chk("sat_hi_nowrap", neg, 0);

        // Saturation low
        repeat (2) tick();
        val[2] = -8'sd128;
        clr(2);
        pulse(2);
        wait_done(2, 1, 200);
        chk("sat_lo_0", fv[2][0], -4);
        chk("sat_lo_31", fv[2][31], -128);
        chk("sat_lo_39", fv[2][39], -128);
        neg = 0;
        for (int i = 0; i < 40; i++)
            if (fv[2][i] > 0) neg++;
        chk("sat_lo_nowrap", neg, 0);

        // Single-sample run; extra start during busy is ignored
        val[3] = 8'sd10;
        clr(3);
        pulse(3);
        chk("one_busy", int'(busy[3]), 1);
        pulse(3);
        wait_done(3, 1, 50);
        repeat (20) tick();
        chk("one_reads", an[3], 1);
        chk("one_encn", en[3], 1);
        chk("one_bit", ev[3][0], 1);
        chk("one_filtn", fn[3], 1);
        chk("one_filt", fv[3][0], 0);
        chk("one_dones", dn[3], 1);
        chk("one_idle", int'(busy[3]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
